// File: rtl/issue_ctrl.sv
// Issue/interlock controller between decode and execute: per-register pending-write
// scoreboard, single multicycle multiplier sequencing, and decode stall generation.
module issue_ctrl #(
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int ALU_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_uses_rt,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_wen,
  input  logic            id_is_mul,
  output logic            stall,
  output logic            issue,
  output logic            mul_start,
  output logic            mul_busy,
  output logic            mul_wb,
  output logic [AW-1:0]   mul_wb_rd,
  output logic [NREG-1:0] busy_mask
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] ALU_V  = CW'(ALU_LAT);
  localparam logic [CW-1:0] MUL_V  = CW'(MUL_LAT);
  localparam logic [CW-1:0] PORT_V = CW'(ALU_LAT + 1);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

  logic [CW-1:0] r_cnt [NREG];
  logic [CW-1:0] r_mul_rem;
  logic [AW-1:0] r_mul_wb_rd;

  logic [CW-1:0] w_cnt_nxt [NREG];
  logic [CW-1:0] w_mul_rem_nxt;
  logic [AW-1:0] w_mul_wb_rd_nxt;
  logic          w_raw;
  logic          w_waw;
  logic          w_struct;
  logic          w_port;
  logic          w_hazard;
  logic          w_stall;
  logic          w_issue;
  logic          w_mul_start;
  mul_state_t    w_mul_state;

  // Hazard terms; reset forces stall/issue/mul_start low regardless of state.
  always_comb begin
    w_raw       = (r_cnt[id_rs] != '0) || (id_uses_rt && (r_cnt[id_rt] != '0));
    w_waw       = id_wen && (r_cnt[id_rd] != '0);
    w_struct    = id_is_mul && (r_mul_rem > ONE_V);
    w_port      = !id_is_mul && id_wen && (r_mul_rem == PORT_V);
    w_hazard    = w_raw || w_waw || w_struct || w_port;
    w_stall     = rst_n && id_valid && w_hazard;
    w_issue     = rst_n && id_valid && !w_hazard;
    w_mul_start = w_issue && id_is_mul;
    w_mul_state = (r_mul_rem != '0) ? MUL_RUN : MUL_IDLE;
  end

  // Next-state: a fresh issue to rd takes priority over the countdown.
  always_comb begin
    w_mul_rem_nxt   = r_mul_rem;
    w_mul_wb_rd_nxt = r_mul_wb_rd;
    busy_mask       = '0;
    if (w_mul_start) begin
      w_mul_rem_nxt   = MUL_V;
      w_mul_wb_rd_nxt = id_rd;
    end else if (w_mul_state == MUL_RUN) begin
      w_mul_rem_nxt = r_mul_rem - ONE_V;
    end
    for (int i = 0; i < NREG; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      busy_mask[i] = (r_cnt[i] != '0);
      if (w_issue && id_wen && (id_rd == AW'(i))) begin
        w_cnt_nxt[i] = id_is_mul ? MUL_V : ALU_V;
      end else if (r_cnt[i] != '0) begin
        w_cnt_nxt[i] = r_cnt[i] - ONE_V;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_mul_rem   <= '0;
      r_mul_wb_rd <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_mul_rem   <= w_mul_rem_nxt;
      r_mul_wb_rd <= w_mul_wb_rd_nxt;
    end
  end

  assign stall     = w_stall;
  assign issue     = w_issue;
  assign mul_start = w_mul_start;
  assign mul_busy  = (w_mul_state == MUL_RUN);
  assign mul_wb    = (r_mul_rem == ONE_V);
  assign mul_wb_rd = r_mul_wb_rd;

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue/interlock controller for the 4-stage pipeline. It sits between decode and execute. It keeps a per-register scoreboard of pending writebacks and sequences the single non-pipelined multicycle multiplier. It stalls decode on RAW hazards, WAW hazards, multiplier busy and writeback-port conflicts. No forwarding exists: a source register is readable only once its write has completed.

## Interface
Parameters:
- NREG, 8, architectural register count
- AW, 3, register address width (2^AW = NREG)
- ALU_LAT, 2, cycles from ALU issue to its writeback cycle (≥1)
- MUL_LAT, 4, cycles from MUL issue to its writeback cycle (> ALU_LAT)

Ports (clock is `clk`; reset is synchronous and active-low, `rst_n`):
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs  in  AW  first source register
- id_rt  in  AW  second source register
- id_uses_rt  in  1  instruction reads rt (0 for ADDI, COM)
- id_rd  in  AW  destination, already resolved by regdst
- id_wen  in  1  instruction writes id_rd
- id_is_mul  in  1  instruction is MUL
- stall  out  1  hold decode and fetch this cycle
- issue  out  1  instruction leaves decode this cycle
- mul_start  out  1  load multiplier operands this cycle
- mul_busy  out  1  multiplier occupied
- mul_wb  out  1  multiplier result written to regfile this cycle
- mul_wb_rd  out  AW  destination of the current multiplier writeback
- busy_mask  out  NREG  bit i set when register i has a pending write

## Operation
- Scoreboard: cnt[i] per register, width clog2(MUL_LAT+1). busy_mask[i] = (cnt[i]≠0).
- On issue with id_wen: cnt[id_rd] ← MUL_LAT if id_is_mul, else ALU_LAT. Every other nonzero cnt decrements by 1 each cycle, saturating at 0.
- Writeback of register i occurs in the cycle where cnt[i]==1. The register is readable when cnt[i]==0.
- Multiplier FSM, state held in mul_rem (0 = IDLE, otherwise RUN):
  - MUL issue: mul_rem ← MUL_LAT.
  - RUN: mul_rem decrements each cycle.
  - mul_wb = (mul_rem==1). mul_busy = (mul_rem≠0).
  - mul_wb_rd is latched at MUL issue and holds until the next MUL issue.
- Stall is the OR of these conditions, each gated by id_valid:
  - RAW: cnt[id_rs]≠0, or id_uses_rt and cnt[id_rt]≠0.
  - WAW: id_wen and cnt[id_rd]≠0.
  - Structural: id_is_mul and mul_rem>1. A new MUL may issue in the mul_wb cycle.
  - Writeback port: ¬id_is_mul and id_wen and mul_rem==ALU_LAT+1. The ALU writeback would otherwise coincide with mul_wb.
- issue = id_valid ∧ ¬stall. mul_start = issue ∧ id_is_mul.
- An issue with id_wen=0 updates no scoreboard entry.

## Timing
- stall, issue and mul_start are combinational from the id_* inputs and the registered state. No added latency: issue in cycle t implies execute in t+1.
- State updates on the rising edge. The issue in cycle t is reflected in cnt, mul_rem and busy_mask from t+1.
- Reset (rst_n=0 at an edge) clears all cnt, mul_rem and mul_wb_rd to 0. This applies mid-operation too: in-flight writes are forgotten and no mul_wb is emitted afterwards.
- While rst_n=0, stall, issue and mul_start are forced to 0.
- After reset: busy_mask=0, mul_busy=0, mul_wb=0, mul_wb_rd=0.
- A cnt reaching 0 and a new issue to the same rd in the same cycle: the issue wins and loads the fresh value.

## Test plan
Parameters NREG=8, ALU_LAT=2, MUL_LAT=4.
- Reset: hold rst_n=0 two cycles with id_valid=1. Required: stall=issue=mul_start=0 and busy_mask=0x00; after release, an independent ADD issues immediately.
- RAW on ALU result: ADD r1 at t0, then SUB reading r1 held from t1. Required: stall=1 at t1–t2, issue at t3, busy_mask=0x02 during t1–t2.
- Structural: MUL r2 at t0, MUL r4 at t1. Required: stall at t1–t3, issue at t4 alongside mul_wb=1 with mul_wb_rd=2, and second mul_wb at t8 with mul_wb_rd=4.
- Port conflict: MUL r2 at t0, then independent ADD r5 presented at t2. Required: stall at t2 (mul_rem=3), issue at t3, r5 written at t5, and mul_wb at t4 only.
- WAW: MUL r3 at t0, then ADD r3 (sources r0,r1, idle) at t1. Required: stall at t1–t4, issue at t5.
- Reset mid-MUL: MUL r6 at t0, rst_n=0 at t2. Required: from t3, mul_busy=0, busy_mask=0, and no mul_wb pulse at t4.
